sd_req_arbiter: RTL
===================

Name: sd_req_arbiter

Overview:
- Shares the single SD block-access port of the HPS I/O bridge (sd_lba/sd_rd/sd_wr/sd_ack plus sector buffer bus) between up to four core requesters, e.g. two emulated disk drives and a tape/cart loader.
- Round-robin arbitration; one sector transfer in flight at a time.
- Latches the LBA and operation at grant and sequences the rd/wr-until-ack handshake.
- Steers buffer traffic and ack to the granted requester only; aborts on a missing ack.

Parameters:
- NREQ, 2, number of requesters (1..4).
- WIDE, 0, 1 = 16-bit sector buffer bus (AW=8, DW=16); 0 = 8-bit (AW=9, DW=8).
- TIMEOUT, 24'd12000000, clk_sys cycles allowed from rd/wr issue to sd_ack rise before abort.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_lba  in  32*NREQ  per-requester sector LBA; slice i = [32i+31:32i].
- req_rd  in  NREQ  per-requester read request level; held until req_ack.
- req_wr  in  NREQ  per-requester write request level; held until req_ack.
- req_ack  out  NREQ  sd_ack routed to the granted requester.
- req_done  out  NREQ  1-cycle pulse when the transfer completes.
- req_err  out  NREQ  1-cycle pulse on timeout abort.
- req_buff_din  in  DW*NREQ  per-requester write data for HPS readout.
- req_buff_wr  out  NREQ  sd_buff_wr gated to the granted requester.
- buff_addr  out  AW  sd_buff_addr broadcast to all requesters.
- buff_dout  out  DW  sd_buff_dout broadcast to all requesters.
- sd_lba  out  32  to HPS I/O.
- sd_rd  out  1  to HPS I/O.
- sd_wr  out  1  to HPS I/O.
- sd_ack  in  1  from HPS I/O.
- sd_buff_addr  in  AW  from HPS I/O.
- sd_buff_dout  in  DW  from HPS I/O.
- sd_buff_wr  in  1  from HPS I/O.
- sd_buff_din  out  DW  to HPS I/O, muxed from the granted requester.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE, grant=0, last=NREQ-1, sd_rd=sd_wr=0, sd_lba=0, req_done=req_err=0, timer=0. Asynchronous assertion clears immediately mid-transfer; the HPS side sees rd/wr drop and the requester must re-request.
- States: IDLE, ISSUE, XFER, DONE.
- IDLE: pending[i] = req_rd[i]|req_wr[i].
  - Pick first pending index searching from last+1 with wrap modulo NREQ.
  - Registered on the next edge: grant one-hot, idx, sd_lba <= req_lba[idx], op latched.
  - If both rd and wr are set, rd is taken; wr stays pending.
  - sd_rd or sd_wr <= 1; timer <= 0; go ISSUE. Latency request -> sd_rd/sd_wr = 1 cycle.
- ISSUE: hold sd_rd/sd_wr and sd_lba; timer increments.
  - sd_ack = 1: drop sd_rd/sd_wr, go XFER.
  - timer == TIMEOUT-1 and no ack: drop rd/wr, pulse req_err[idx], last <= idx, go IDLE.
  - Requester dropping its request in ISSUE is ignored; the transfer proceeds.
- XFER: wait for sd_ack = 0. Then pulse req_done[idx] for one cycle, last <= idx, go DONE.
- DONE: one cycle, grant <= 0, go IDLE. Guarantees a new sd_rd is never issued in the cycle ack falls.
- Steering, combinational so address/data/strobe stay aligned:
  - req_ack = {NREQ{sd_ack}} & grant.
  - req_buff_wr = {NREQ{sd_buff_wr}} & grant.
  - buff_addr = sd_buff_addr; buff_dout = sd_buff_dout.
  - sd_buff_din = req_buff_din slice idx; 0 when grant = 0.
- sd_ack or sd_buff_wr seen in IDLE/DONE (stray) is discarded: grant = 0 masks it.
- Fairness: every pending requester is served within NREQ grants.

Decomposition:
- Package sd_arb_pkg: state enum (IDLE/ISSUE/XFER/DONE); AW/DW width functions of WIDE; default TIMEOUT constant.
- One sub-module, rr_pick: combinational round-robin finder (pending, last -> idx, valid), reusable elsewhere.

Test Plan:
- Single read: NREQ=2, req_rd[0]=1, req_lba[31:0]=0x1234. Expect sd_rd=1 with sd_lba=0x1234 one cycle later. sd_ack rise -> sd_rd=0, req_ack[0]=1. Then 512 sd_buff_wr pulses appear only on req_buff_wr[0]. Ack falls -> req_done[0] one cycle.
- Contention: req_rd[0] and req_wr[1] asserted together from reset. Order is 0 then 1. During 1's write, sd_buff_din equals req_buff_din[1] for addresses 0..511.
- Round-robin: both requesters re-request continuously for 4 transfers. Expect grant sequence 0,1,0,1; no idle gap longer than 2 cycles.
- Timeout: TIMEOUT=16, req_wr[1]=1, sd_ack never asserts. Expect sd_wr low after 16 cycles, req_err[1] pulse, return to IDLE; req_done stays 0.
- rd+wr same requester: req_rd[0]=req_wr[0]=1. Read served first, then write; two req_done[0] pulses.
- Reset mid-XFER: assert reset while sd_ack=1. Same-cycle sd_rd=sd_wr=0, req_ack=0, busy=0; a subsequent sd_buff_wr produces no req_buff_wr.

Source files
------------

// File: rtl/sd_arb_pkg.sv
// sd_arb_pkg: shared definitions for the SD request arbiter.
//   arb_state_t      arbiter sequencing states
//   buff_aw/buff_dw  sector buffer address/data width for a bus mode
//                    (wide=1: 16-bit words, 256 deep; wide=0: bytes, 512 deep)
//   idx_w            width of a requester index for n requesters
//   TIMEOUT_DEFAULT  clk_sys cycles allowed from rd/wr issue to sd_ack
package sd_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      XFER  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   localparam logic [23:0] TIMEOUT_DEFAULT = 24'd12000000;

   function automatic int buff_aw(input int wide);
      return (wide != 0) ? 8 : 9;
   endfunction

   function automatic int buff_dw(input int wide);
      return (wide != 0) ? 16 : 8;
   endfunction

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sd_req_arbiter_rr_pick.sv
// rr_pick: combinational round-robin finder.
//   pending  in   NREQ  request vector
//   last     in   IW    index served most recently
//   idx      out  IW    first pending index searching from last+1, wrapping
//   valid    out  1     at least one request pending
module rr_pick
   import sd_arb_pkg::*;
#(
   parameter int NREQ = 2,
   localparam int IW = idx_w(NREQ)
)(
   input  logic [NREQ-1:0] pending,
   input  logic [IW-1:0]   last,
   output logic [IW-1:0]   idx,
   output logic            valid
);

   // Walk the candidates from farthest to nearest so the nearest pending
   // one (lowest offset from last) is the final assignment and wins.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int k = NREQ; k >= 1; k--) begin
         if (pending[(int'(last) + k) % NREQ]) begin
            idx   = IW'((int'(last) + k) % NREQ);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sd_req_arbiter.sv
// sd_req_arbiter: shares the HPS I/O SD block port between NREQ requesters.
// One sector transfer in flight; round-robin grant; LBA/op latched at grant.
//   clk_sys, reset              clock, asynchronous active-high reset
//   req_lba/req_rd/req_wr       per-requester request (levels, held until ack)
//   req_ack/req_done/req_err    per-requester ack, completion and abort pulses
//   req_buff_din/req_buff_wr    per-requester buffer readout data / write strobe
//   buff_addr/buff_dout         buffer address/data broadcast to requesters
//   sd_lba/sd_rd/sd_wr/sd_ack   HPS I/O block request handshake
//   sd_buff_addr/_dout/_wr/_din HPS I/O sector buffer bus
//   busy                        arbiter not idle
module sd_req_arbiter
   import sd_arb_pkg::*;
#(
   parameter int          NREQ    = 2,
   parameter int          WIDE    = 0,
   parameter logic [23:0] TIMEOUT = TIMEOUT_DEFAULT,
   localparam int AW = buff_aw(WIDE),
   localparam int DW = buff_dw(WIDE),
   localparam int IW = idx_w(NREQ)
)(
   input  logic               clk_sys,
   input  logic               reset,
   input  logic [32*NREQ-1:0] req_lba,
   input  logic [NREQ-1:0]    req_rd,
   input  logic [NREQ-1:0]    req_wr,
   output logic [NREQ-1:0]    req_ack,
   output logic [NREQ-1:0]    req_done,
   output logic [NREQ-1:0]    req_err,
   input  logic [DW*NREQ-1:0] req_buff_din,
   output logic [NREQ-1:0]    req_buff_wr,
   output logic [AW-1:0]      buff_addr,
   output logic [DW-1:0]      buff_dout,
   output logic [31:0]        sd_lba,
   output logic               sd_rd,
   output logic               sd_wr,
   input  logic               sd_ack,
   input  logic [AW-1:0]      sd_buff_addr,
   input  logic [DW-1:0]      sd_buff_dout,
   input  logic               sd_buff_wr,
   output logic [DW-1:0]      sd_buff_din,
   output logic               busy
);

   arb_state_t        state_reg;
   logic [NREQ-1:0]   grant_reg;
   logic [IW-1:0]     idx_reg;
   logic [IW-1:0]     last_reg;
   logic [23:0]       timer_reg;

   logic [NREQ-1:0]   pending;
   logic [IW-1:0]     pick_idx;
   logic              pick_valid;
   logic [NREQ-1:0]   pick_onehot;
   logic [31:0]       lba_arr [NREQ];
   logic [DW-1:0]     din_arr [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_slice
         assign lba_arr[gi]     = req_lba[32*gi +: 32];
         assign din_arr[gi]     = req_buff_din[DW*gi +: DW];
         assign pick_onehot[gi] = (pick_idx == IW'(gi));
      end
   endgenerate

   assign pending = req_rd | req_wr;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .pending (pending),
      .last    (last_reg),
      .idx     (pick_idx),
      .valid   (pick_valid)
   );

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         grant_reg <= '0;
         idx_reg   <= '0;
         last_reg  <= IW'(NREQ - 1);
         timer_reg <= '0;
         sd_lba    <= '0;
         sd_rd     <= 1'b0;
         sd_wr     <= 1'b0;
         req_done  <= '0;
         req_err   <= '0;
      end else begin
         req_done <= '0;
         req_err  <= '0;
         case (state_reg)
            IDLE: begin
               if (pick_valid) begin
                  grant_reg <= pick_onehot;
                  idx_reg   <= pick_idx;
                  sd_lba    <= lba_arr[pick_idx];
                  // A read wins over a simultaneous write; the write stays
                  // pending and is taken on a later grant.
                  sd_rd     <= req_rd[pick_idx];
                  sd_wr     <= ~req_rd[pick_idx];
                  timer_reg <= '0;
                  state_reg <= ISSUE;
               end
            end
            ISSUE: begin
               timer_reg <= timer_reg + 24'd1;
               if (sd_ack) begin
                  sd_rd     <= 1'b0;
                  sd_wr     <= 1'b0;
                  state_reg <= XFER;
               end else if (timer_reg == TIMEOUT - 24'd1) begin
                  sd_rd     <= 1'b0;
                  sd_wr     <= 1'b0;
                  req_err   <= grant_reg;
                  last_reg  <= idx_reg;
                  grant_reg <= '0;
                  state_reg <= IDLE;
               end
            end
            XFER: begin
               if (!sd_ack) begin
                  req_done  <= grant_reg;
                  last_reg  <= idx_reg;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               // Spacer cycle: keeps a fresh sd_rd/sd_wr away from the
               // cycle in which the previous ack fell.
               grant_reg <= '0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Steering stays combinational so address, data and strobe remain aligned
   // with the HPS bus; grant=0 masks stray ack/write strobes.
   assign req_ack     = {NREQ{sd_ack}} & grant_reg;
   assign req_buff_wr = {NREQ{sd_buff_wr}} & grant_reg;
   assign buff_addr   = sd_buff_addr;
   assign buff_dout   = sd_buff_dout;
   assign sd_buff_din = (|grant_reg) ? din_arr[idx_reg] : '0;
   assign busy        = (state_reg != IDLE);

endmodule
